// File: rtl/gray_position_decoder.sv
// -----------------------------------------------------------------------------
// gray_position_decoder
//
// Receives a Gray-coded position word (encoder wheel / position sensor) that is
// asynchronous to clk. It synchronizes the word and converts it to binary. It
// classifies every change of the decoded position as a single step up, a single
// step down, or an illegal jump, and keeps a wrapping position counter.
//
// Ports:
//   clk         in   1      system clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   gray        in   WIDTH  Gray-coded position, asynchronous to clk
//   clr         in   1      synchronous clear of count and err_sticky
//   bin         out  WIDTH  registered binary of the synchronized gray word
//   valid       out  1      high once the first post-reset sample is decoded
//   step_up     out  1      one-cycle pulse, position moved +1 (mod 2^WIDTH)
//   step_dn     out  1      one-cycle pulse, position moved -1 (mod 2^WIDTH)
//   err         out  1      one-cycle pulse, jump other than 0/+1/-1
//   err_sticky  out  1      set by err, held until clr or reset
//   count       out  CNT_W  running position count, wraps both ways
//
// Latency: a gray change captured into s1 at edge n is on bin at edge n+2.
// The step/err pulses are registered on the same edge as bin.
// -----------------------------------------------------------------------------
module gray_position_decoder #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray,
  input  logic             clr,
  output logic [WIDTH-1:0] bin,
  output logic             valid,
  output logic             step_up,
  output logic             step_dn,
  output logic             err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] count
);

  localparam logic [WIDTH-1:0] POS_ONE = WIDTH'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    MOV_NONE = 2'd0,
    MOV_UP   = 2'd1,
    MOV_DN   = 2'd2,
    MOV_ERR  = 2'd3
  } move_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] nb;
  move_t            move;
  logic             up_nxt;
  logic             dn_nxt;
  logic             err_nxt;
  logic             sticky_nxt;
  logic [CNT_W-1:0] count_nxt;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // The modular difference classifies the move. -1 mod 2^WIDTH is all ones,
  // so the wrap 0 -> max counts as a step down, and the wrap max -> 0 as a
  // step up.
  function automatic move_t classify(input logic [WIDTH-1:0] cur,
                                     input logic [WIDTH-1:0] prev);
    logic [WIDTH-1:0] d;
    move_t            m;
    d = cur - prev;
    if (d == '0) begin
      m = MOV_NONE;
    end else if (d == POS_ONE) begin
      m = MOV_UP;
    end else if (d == '1) begin
      m = MOV_DN;
    end else begin
      m = MOV_ERR;
    end
    return m;
  endfunction

  // Synchronizer: two flops on the asynchronous Gray bus. With Gray coding,
  // only one bit changes per legal step, so a sample caught mid-transition
  // resolves to either the old position or the new position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= gray;
      s2 <= s1;
    end
  end

  assign nb = gray_to_bin(s2);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, move classification and next output values. In INIT, bin has
  // no meaningful previous value yet, so no move is reported on that edge.
  always_comb begin
    state_nxt  = state;
    move       = MOV_NONE;
    up_nxt     = 1'b0;
    dn_nxt     = 1'b0;
    err_nxt    = 1'b0;
    count_nxt  = count;
    sticky_nxt = err_sticky;

    case (state)
      INIT: begin
        state_nxt = TRACK;
      end
      TRACK: begin
        move = classify(nb, bin);
      end
      default: begin
        state_nxt = INIT;
      end
    endcase

    case (move)
      MOV_UP: begin
        up_nxt    = 1'b1;
        count_nxt = count + CNT_ONE;
      end
      MOV_DN: begin
        dn_nxt    = 1'b1;
        count_nxt = count - CNT_ONE;
      end
      MOV_ERR: begin
        err_nxt    = 1'b1;
        sticky_nxt = 1'b1;
      end
      default: begin
      end
    endcase

    // clr wins over a same-edge count update or err set. It does not
    // suppress the pulses.
    if (clr) begin
      count_nxt  = '0;
      sticky_nxt = 1'b0;
    end
  end

  // Output registers. bin is reloaded on every edge, in INIT and in TRACK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin        <= '0;
      valid      <= 1'b0;
      step_up    <= 1'b0;
      step_dn    <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      count      <= '0;
    end else begin
      bin        <= nb;
      valid      <= 1'b1;
      step_up    <= up_nxt;
      step_dn    <= dn_nxt;
      err        <= err_nxt;
      err_sticky <= sticky_nxt;
      count      <= count_nxt;
    end
  end

endmodule

// File: tb/tb_gray_position_decoder.sv
module tb_gray_position_decoder;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] gray;
  logic             clr;
  logic [WIDTH-1:0] bin;
  logic             valid;
  logic             step_up;
  logic             step_dn;
  logic             err;
  logic             err_sticky;
  logic [CNT_W-1:0] count;

  always #5 clk = ~clk;

  gray_position_decoder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gray       (gray),
    .clr        (clr),
    .bin        (bin),
    .valid      (valid),
    .step_up    (step_up),
    .step_dn    (step_dn),
    .err        (err),
    .err_sticky (err_sticky),
    .count      (count)
  );

  typedef struct packed {
    logic [3:0] b;
    logic       v;
    logic       up;
    logic       dn;
    logic       er;
    logic       st;
    logic [7:0] c;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", name, obs, expv);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] b, input logic v,
                            input logic up, input logic dn, input logic er,
                            input logic st, input logic [7:0] c);
    exp_t e;
    e.b  = b;
    e.v  = v;
    e.up = up;
    e.dn = dn;
    e.er = er;
    e.st = st;
    e.c  = c;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic compare_out();
    exp_t  e;
    string t;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed 0 entries, expected at least 1");
    end else begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      chk({t, ".bin"},        {4'b0, bin},        {4'b0, e.b});
      chk({t, ".valid"},      {7'b0, valid},      {7'b0, e.v});
      chk({t, ".step_up"},    {7'b0, step_up},    {7'b0, e.up});
      chk({t, ".step_dn"},    {7'b0, step_dn},    {7'b0, e.dn});
      chk({t, ".err"},        {7'b0, err},        {7'b0, e.er});
      chk({t, ".err_sticky"}, {7'b0, err_sticky}, {7'b0, e.st});
      chk({t, ".count"},      count,              e.c);
    end
  endtask

  // Called at a negedge. Drives a new gray word, expects the decoded result
  // two edges after capture (optionally with clr high on that update edge).
  // Then it checks that the pulse has dropped and the state holds.
  task automatic step(input string tag, input logic [3:0] g, input logic clr_at_update,
                      input logic [3:0] b, input logic up, input logic dn,
                      input logic er, input logic st, input logic [7:0] c);
    gray = g;
    expect_out(tag, b, 1'b1, up, dn, er, st, c);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    clr = clr_at_update;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    compare_out();
    expect_out({tag, "_hold"}, b, 1'b1, 1'b0, 1'b0, 1'b0, st, c);
    @(posedge clk);
    @(negedge clk);
    compare_out();
    @(negedge clk);
  endtask

  task automatic clr_pulse(input string tag, input logic [3:0] b);
    clr = 1'b1;
    expect_out(tag, b, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    compare_out();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish by 100000, expected earlier finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Test 1: gray 0110 is held through reset. INIT loads s2 = 0, and then
    // the decode of 0110 is an illegal jump of 4.
    rst_n = 1'b0;
    clr   = 1'b0;
    gray  = 4'b0110;
    repeat (3) @(negedge clk);
    expect_out("t1_reset", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    compare_out();
    rst_n = 1'b1;
    expect_out("t1_init", 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    @(negedge clk);
    compare_out();
    expect_out("t1_track0", 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    @(negedge clk);
    compare_out();
    expect_out("t1_err", 4'h4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    @(posedge clk);
    @(negedge clk);
    compare_out();
    expect_out("t1_hold", 4'h4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    @(posedge clk);
    @(negedge clk);
    compare_out();

    // Test 2: fresh reset with gray 0000, then three legal up steps.
    rst_n = 1'b0;
    gray  = 4'b0000;
    @(negedge clk);
    expect_out("t2_reset", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    compare_out();
    @(negedge clk);
    rst_n = 1'b1;
    expect_out("t2_init", 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    @(negedge clk);
    compare_out();
    step("t2_up1", 4'b0001, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
    step("t2_up2", 4'b0011, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02);
    step("t2_up3", 4'b0010, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 8'h03);

    // Tests 3 and 5: walk down through 0, the count underflows to FF. Then
    // wrap bin F -> 0 (up) and 0 -> F (down).
    step("t3_dn1",  4'b0011, 1'b0, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 8'h02);
    step("t3_dn2",  4'b0001, 1'b0, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01);
    step("t3_dn3",  4'b0000, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step("t5_under", 4'b1000, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
    step("t3_wrapup", 4'b0000, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step("t3_wrapdn", 4'b1000, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);

    // Test 4: illegal jumps, sticky hold, and clr.
    step("t4_err1", 4'b1010, 1'b0, 4'hC, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF);
    clr_pulse("t4_clr1", 4'hC);
    step("t4_err2", 4'b1000, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    step("t4_upst", 4'b0000, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01);
    step("t4_err3", 4'b0011, 1'b0, 4'h2, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01);
    clr_pulse("t4_clr2", 4'h2);

    // Test 5b: clr on the update edge overrides the count and sticky
    // updates, but the pulses still fire.
    step("t5_up",     4'b0010, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
    step("t5_dnclr",  4'b0011, 1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step("t5_errclr", 4'b0100, 1'b1, 4'h7, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

    // Test 6: asynchronous reset in the middle of a sweep.
    step("t6_up1", 4'b1100, 1'b0, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
    step("t6_up2", 4'b1101, 1'b0, 4'h9, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02);
    gray = 4'b1111;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("t6_async", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    compare_out();
    gray = 4'b0001;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_out("t6_init", 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    @(negedge clk);
    compare_out();
    expect_out("t6_track0", 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    @(negedge clk);
    compare_out();
    // The first decode from s2 = 0 to the held word is a legal +1 here.
    expect_out("t6_first", 4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
    @(posedge clk);
    @(negedge clk);
    compare_out();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
